// File: rtl/tfe_hash_pkg.sv
// Shared types and constants for the TFE hashing path.
// HASH_ARB_SYM_EN adds a direction-independent sym_hash field to hash_res_t.
package tfe_hash_pkg;

  localparam int unsigned TUPLE_W  = 104;
  localparam int unsigned HASH_W   = 32;
  localparam int unsigned RES_ID_W = 4;  // wide enough for up to 16 requesters
  localparam logic [HASH_W-1:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [HASH_W-1:0] CRC_POLY = 32'h04C1_1DB7;

  typedef struct packed {
    logic [HASH_W-1:0]   hash;
    logic [HASH_W-1:0]   r_hash;
    logic [RES_ID_W-1:0] id;
`ifdef HASH_ARB_SYM_EN
    logic [HASH_W-1:0]   sym_hash;
`endif
  } hash_res_t;

  // MSB-first CRC32 over a full tuple, no output inversion.
  function automatic logic [HASH_W-1:0] crc32_d104(input logic [TUPLE_W-1:0] d,
                                                   input logic [HASH_W-1:0]  init);
    logic [HASH_W-1:0] c;
    logic              fb;
    c = init;
    for (int i = TUPLE_W - 1; i >= 0; i--) begin
      fb = c[HASH_W-1] ^ d[i];
      c  = {c[HASH_W-2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/hashing.sv
// Hashing unit: forward and reverse CRC32 of an IP tuple, HASH_LAT register stages.
module hashing
  import tfe_hash_pkg::*;
#(
  parameter int unsigned HASH_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TUPLE_W-1:0] ip_tuple,
  input  logic [TUPLE_W-1:0] ip_r_tuple,
  input  logic               ip_tuple_v,
  output logic [HASH_W-1:0]  hash,
  output logic [HASH_W-1:0]  r_hash,
  output logic               hash_v
);

  logic [HASH_W-1:0]   h_q  [HASH_LAT];
  logic [HASH_W-1:0]   rh_q [HASH_LAT];
  logic [HASH_LAT-1:0] v_q;

  // Valid pipeline, the only state that needs reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q[0] <= ip_tuple_v;
      for (int i = 1; i < HASH_LAT; i++) v_q[i] <= v_q[i-1];
    end
  end

  // Data pipeline; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    h_q[0]  <= crc32_d104(ip_tuple, CRC_INIT);
    rh_q[0] <= crc32_d104(ip_r_tuple, CRC_INIT);
    for (int i = 1; i < HASH_LAT; i++) begin
      h_q[i]  <= h_q[i-1];
      rh_q[i] <= rh_q[i-1];
    end
  end

  assign hash   = h_q[HASH_LAT-1];
  assign r_hash = rh_q[HASH_LAT-1];
  assign hash_v = v_q[HASH_LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] lane;
  logic            found;

  // Scan lanes ptr, ptr+1, ... mod NUM_REQ; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    lane  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane = ID_W'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (en && !found && req[lane]) begin
        gnt[lane] = 1'b1;
        idx       = lane;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_req_arbiter.sv
// Shares one hashing unit between NUM_REQ requesters; results buffered in a
// credit-protected FIFO. HASH_ARB_SYM_EN adds res_sym_hash = min(hash, r_hash).
module hash_req_arbiter
  import tfe_hash_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned HASH_LAT  = 1,
  parameter int unsigned RES_DEPTH = 4,
  localparam int unsigned CNT_W    = $clog2(RES_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*TUPLE_W-1:0] req_tuple,
  input  logic [NUM_REQ*TUPLE_W-1:0] req_r_tuple,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [HASH_W-1:0]          res_hash,
  output logic [HASH_W-1:0]          res_r_hash,
  output logic [ID_W-1:0]            res_id,
`ifdef HASH_ARB_SYM_EN
  output logic [HASH_W-1:0]          res_sym_hash,
`endif
  output logic [CNT_W-1:0]           inflight
);

  localparam int unsigned PTR_W = $clog2(RES_DEPTH);

  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [NUM_REQ-1:0]  gnt;
  logic                grant_en, accept;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d, pipe_cnt, used;
  logic [ID_W-1:0]     id_pipe_q [HASH_LAT];
  logic [HASH_LAT-1:0] vld_pipe_q;
  logic [HASH_W-1:0]   hash, r_hash;
  logic                hash_v, hash_rst_n, push, pop;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  hash_res_t           mem_q [RES_DEPTH];
  hash_res_t           wr_data, rd_data;

  // Credits count results that are hashing or buffered, so the FIFO can never overflow.
  assign used     = fifo_cnt_q + pipe_cnt;
  assign grant_en = used < CNT_W'(RES_DEPTH);
  assign inflight = used;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (grant_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  // Pointer moves just past the lane that was accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  end

  assign hash_rst_n = ~rst;

  hashing #(
    .HASH_LAT (HASH_LAT)
  ) u_hash (
    .clk        (clk),
    .rst_n      (hash_rst_n),
    .ip_tuple   (req_tuple[gnt_idx*TUPLE_W +: TUPLE_W]),
    .ip_r_tuple (req_r_tuple[gnt_idx*TUPLE_W +: TUPLE_W]),
    .ip_tuple_v (accept),
    .hash       (hash),
    .r_hash     (r_hash),
    .hash_v     (hash_v)
  );

  // Requester ID travels alongside the tuple; the valid bits feed the credit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < HASH_LAT; i++) id_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= accept;
      id_pipe_q[0]  <= gnt_idx;
      for (int i = 1; i < HASH_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        id_pipe_q[i]  <= id_pipe_q[i-1];
      end
    end
  end

  // Number of tuples currently inside the hashing pipeline.
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < HASH_LAT; i++) pipe_cnt = pipe_cnt + CNT_W'(vld_pipe_q[i]);
  end

  // Assemble the FIFO entry at write time.
  always_comb begin
    wr_data        = '0;
    wr_data.hash   = hash;
    wr_data.r_hash = r_hash;
    wr_data.id     = RES_ID_W'(id_pipe_q[HASH_LAT-1]);
`ifdef HASH_ARB_SYM_EN
    wr_data.sym_hash = (hash < r_hash) ? hash : r_hash;
`endif
  end

  assign push    = hash_v;
  assign pop     = res_valid & res_ready;
  assign rd_data = mem_q[rd_ptr_q];

  // FIFO occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
  end

  // Control state: round-robin pointer and FIFO pointers/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Result storage; stale entries are never visible because res_valid gates the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Outputs read straight from storage and forced to zero while empty.
  always_comb begin
    res_valid  = fifo_cnt_q != '0;
    res_hash   = res_valid ? rd_data.hash : '0;
    res_r_hash = res_valid ? rd_data.r_hash : '0;
    res_id     = res_valid ? ID_W'(rd_data.id) : '0;
`ifdef HASH_ARB_SYM_EN
    res_sym_hash = res_valid ? rd_data.sym_hash : '0;
`endif
  end

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Randomised bench for hash_req_arbiter with a queue scoreboard and a reference
// model of arbitration, credits and CRC32 (long division). Covers HASH_ARB_SYM_EN when set.
module tb_hash_req_arbiter;
  import tfe_hash_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*104-1:0] req_tuple, req_r_tuple;
  logic [N-1:0]     req_valid, req_ready;
  logic             res_valid, res_ready;
  logic [31:0]      res_hash, res_r_hash;
  logic [IDW-1:0]   res_id;
  logic [CW-1:0]    inflight;
`ifdef HASH_ARB_SYM_EN
  logic [31:0]      res_sym_hash;
`endif

  hash_req_arbiter #(
    .NUM_REQ   (N),
    .ID_W      (IDW),
    .HASH_LAT  (LAT),
    .RES_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_tuple    (req_tuple),
    .req_r_tuple  (req_r_tuple),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_hash     (res_hash),
    .res_r_hash   (res_r_hash),
    .res_id       (res_id),
`ifdef HASH_ARB_SYM_EN
    .res_sym_hash (res_sym_hash),
`endif
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] h, rh, sym;
    bit          chk_lat;
    int          acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0, fails = 0;
  logic [103:0] lt[N], lrt[N];
  logic [N-1:0] lv = '0, acc_mask = '0;
  int           m_ptr = 0, m_infl = 0, dut_acc = 0;
  bit           use_fix = 0, lat_chk = 0;
  logic [103:0] fix_t, fix_rt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // CRC as remainder of (init*x^104 + data*x^32) mod P.
  function automatic logic [31:0] ref_crc(input logic [103:0] d);
    logic [135:0] m;
    m = {d, 32'h0} ^ {32'hFFFF_FFFF, 104'h0};
    for (int i = 135; i >= 32; i--)
      if (m[i]) m[i-:33] = m[i-:33] ^ {1'b1, 32'h04C1_1DB7};
    return m[31:0];
  endfunction

  function automatic logic [103:0] rand_t();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[103:0];
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      req_tuple[i*104 +: 104]   = lt[i];
      req_r_tuple[i*104 +: 104] = lrt[i];
    end
    req_valid = lv;
  endtask

  // Model: first valid lane from m_ptr wins if fewer than DEPTH results are outstanding.
  task automatic check_cycle();
    int           lane;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    lane    = -1;
    exp_rdy = '0;
    if (lv != 0 && m_infl < int'(DEPTH))
      for (int k = 0; k < N; k++)
        if (lane < 0 && lv[(m_ptr + k) % N]) lane = (m_ptr + k) % N;
    if (lane >= 0) exp_rdy[lane] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("inflight", 64'(inflight), 64'(m_infl));
    if ((req_ready & lv) != 0) dut_acc++;
    if (lane >= 0) begin
      e.id      = 2'(lane);
      e.h       = ref_crc(lt[lane]);
      e.rh      = ref_crc(lrt[lane]);
      e.sym     = (e.h < e.rh) ? e.h : e.rh;
      e.chk_lat = lat_chk;
      e.acc_cyc = cyc;
      sb.push_back(e);
      m_infl++;
      m_ptr = (lane + 1) % N;
      acc_mask[lane] = 1'b1;
    end
  endtask

  // Lanes that are idle or just accepted may take a fresh tuple; waiting lanes hold.
  task automatic cycle(input logic [N-1:0] want, input bit rdy);
    for (int i = 0; i < N; i++)
      if (!lv[i] || acc_mask[i]) begin
        lv[i] = want[i];
        if (want[i]) begin
          lt[i]  = use_fix ? fix_t : rand_t();
          lrt[i] = use_fix ? fix_rt : rand_t();
        end
      end
    acc_mask  = '0;
    res_ready = rdy;
    drive_lanes();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || lv != 0); i++) cycle('0, 1'b1);
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Monitor: pop expected entry on every output handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0 && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got id %0d hash %0h expected none", res_id, res_hash);
        end else begin
          e = sb.pop_front();
          chk("res_id", 64'(res_id), 64'(e.id));
          chk("res_hash", 64'(res_hash), 64'(e.h));
          chk("res_r_hash", 64'(res_r_hash), 64'(e.rh));
`ifdef HASH_ARB_SYM_EN
          chk("res_sym_hash", 64'(res_sym_hash), 64'(e.sym));
`endif
          if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(LAT + 1));
          m_infl--;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      lt[i]  = '0;
      lrt[i] = '0;
    end
    rst       = 1'b1;
    res_ready = 1'b0;
    drive_lanes();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_hash", 64'(res_hash), 64'(0));
    chk("rst_res_r_hash", 64'(res_r_hash), 64'(0));
    chk("rst_res_id", 64'(res_id), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    @(posedge clk);
    #1;

    // Single zero tuple on lane 0 with latency check.
    use_fix = 1; lat_chk = 1; fix_t = '0; fix_rt = '0;
    cycle(4'b0001, 1'b1);
    use_fix = 0; lat_chk = 0;
    drain();

    // All lanes continuously valid.
    repeat (12) cycle(4'hF, 1'b1);
    drain();

    // Output stalled: exactly DEPTH accepts, then release and resume.
    dut_acc = 0;
    repeat (8) cycle(4'b1010, 1'b0);
    chk("stall_accepts", 64'(dut_acc), 64'(DEPTH));
    chk("stall_inflight", 64'(inflight), 64'(DEPTH));
    repeat (4) cycle(4'b1010, 1'b1);
    drain();

    // Full FIFO released while requests are pending.
    repeat (6) cycle(4'hF, 1'b0);
    repeat (10) cycle(4'hF, 1'b1);
    drain();

    // Random traffic and backpressure.
    repeat (400) cycle(4'($urandom()), $urandom_range(0, 3) != 0);
    drain();

    // Reset with three results outstanding.
    repeat (3) cycle(4'b0001, 1'b0);
    rst = 1'b1; lv = '0; res_ready = 1'b0;
    drive_lanes();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_infl = 0; m_ptr = 0; acc_mask = '0;
    @(negedge clk);
    chk("midrst_res_valid", 64'(res_valid), 64'(0));
    chk("midrst_inflight", 64'(inflight), 64'(0));
    @(posedge clk);
    #1;
    repeat (3) cycle('0, 1'b1);
    cycle(4'hF, 1'b1);
    drain();

`ifdef HASH_ARB_SYM_EN
    // Swapped directions must give the same symmetric key.
    use_fix = 1; fix_t = rand_t(); fix_rt = rand_t();
    cycle(4'b0001, 1'b1);
    begin
      logic [103:0] tmp;
      tmp = fix_t; fix_t = fix_rt; fix_rt = tmp;
    end
    cycle(4'b0001, 1'b1);
    use_fix = 0;
    drain();
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
